// File: rtl/cprv_pkg.sv
// Shared types and constants for the CPRV instruction-fetch stage.
package cprv_pkg;

    localparam int CPRV_INSTR_WIDTH    = 32;
    localparam int CPRV_ADDR_WIDTH     = 64;
    localparam int CPRV_IF_FIFO_DEPTH  = 2;

    // addi x0, x0, 0
    localparam logic [CPRV_INSTR_WIDTH-1:0] CPRV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [CPRV_ADDR_WIDTH-1:0]  pc;
        logic [CPRV_INSTR_WIDTH-1:0] instr;
    } cprv_fetch_entry_t;

endpackage

// File: rtl/cprv_if_fifo.sv
// Two-entry in-order FIFO holding {pc, instr} fetch entries for the ID stage.
module cprv_if_fifo
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH = CPRV_ADDR_WIDTH + CPRV_INSTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem [CPRV_IF_FIFO_DEPTH];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count_reg == 2'd2);
    assign empty     = (count_reg == 2'd0);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];

    // A pop frees the slot in the same cycle, so push-while-full is legal alongside a pop.
    assign do_push = push & ~flush & (~full | pop);
    assign do_pop  = pop & ~empty;

    genvar gi;
    generate
        for (gi = 0; gi < CPRV_IF_FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/cprv_if_stage.sv
// CPRV instruction-fetch stage: credit-limited fetch, 2-entry ID queue.
// Define CPRV_IF_REDIRECT_EN to add redirect ports and in-flight response dropping.
module cprv_if_stage
    import cprv_pkg::*;
#(
    parameter int                    INSTR_WIDTH = CPRV_INSTR_WIDTH,
    parameter int                    ADDR_WIDTH  = CPRV_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
`ifdef CPRV_IF_REDIRECT_EN
    input  logic                   redirect_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
`endif
    output logic                   valid_id_o,
    input  logic                   ready_id_i,
    output logic [INSTR_WIDTH-1:0] instr_data_id_o,
    output logic [ADDR_WIDTH-1:0]  pc_id_o
);

    localparam int ENTRY_WIDTH = ADDR_WIDTH + INSTR_WIDTH;

    logic [ADDR_WIDTH-1:0]  pc_reg;
    logic [ADDR_WIDTH-1:0]  pc_next;
    logic [ADDR_WIDTH-1:0]  resp_pc_reg;
    logic [ADDR_WIDTH-1:0]  resp_pc_next;
    logic [1:0]             out_cnt_reg;
    logic [1:0]             out_cnt_next;
    logic                   run_reg;
    logic                   credit_ok;
    logic                   gnt_acc;
    logic                   redirect_act;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   discard;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [1:0]             fifo_count;
    logic [ENTRY_WIDTH-1:0] fifo_head;

`ifdef CPRV_IF_REDIRECT_EN
    logic [1:0] drop_cnt_reg;
    logic [1:0] drop_cnt_next;

    assign redirect_act = redirect_i;
    assign redirect_pc  = redirect_pc_i;
    assign discard      = imem_rvalid_i & (drop_cnt_reg != 2'd0);
`else
    assign redirect_act = 1'b0;
    assign redirect_pc  = '0;
    assign discard      = 1'b0;
`endif

    // Outstanding fetches plus queued entries may never exceed the queue depth.
    assign credit_ok   = ({1'b0, out_cnt_reg} + {1'b0, fifo_count}) < 3'd2;
    assign imem_req_o  = run_reg & credit_ok & ~redirect_act;
    assign imem_addr_o = pc_reg;

    // A grant seen during a redirect is still in flight on the old path and must be dropped later.
    assign gnt_acc = imem_gnt_i & (imem_req_o | redirect_act);

    assign fifo_push = imem_rvalid_i & ~discard & ~redirect_act;
    assign fifo_pop  = valid_id_o & ready_id_i;

    always_comb begin
        out_cnt_next = out_cnt_reg + {1'b0, gnt_acc} - {1'b0, imem_rvalid_i};

        pc_next = pc_reg;
        if (redirect_act) begin
            pc_next = redirect_pc;
        end else if (imem_req_o && imem_gnt_i) begin
            pc_next = pc_reg + ADDR_WIDTH'(4);
        end

        // Responses return in order, so the next kept response is always the next sequential PC.
        resp_pc_next = resp_pc_reg;
        if (redirect_act) begin
            resp_pc_next = redirect_pc;
        end else if (fifo_push) begin
            resp_pc_next = resp_pc_reg + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg      <= RESET_PC;
            resp_pc_reg <= RESET_PC;
            out_cnt_reg <= 2'd0;
            run_reg     <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            resp_pc_reg <= resp_pc_next;
            out_cnt_reg <= out_cnt_next;
            run_reg     <= 1'b1;
        end
    end

`ifdef CPRV_IF_REDIRECT_EN
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (redirect_act) begin
            drop_cnt_next = out_cnt_next;
        end else if (discard) begin
            drop_cnt_next = drop_cnt_reg - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= 2'd0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
        end
    end
`endif

    cprv_if_fifo #(
        .DATA_WIDTH (ENTRY_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_act),
        .push      (fifo_push),
        .push_data ({resp_pc_reg, imem_rdata_i}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign valid_id_o      = ~fifo_empty;
    assign pc_id_o         = fifo_head[ENTRY_WIDTH-1:INSTR_WIDTH];
    assign instr_data_id_o = fifo_head[INSTR_WIDTH-1:0];

`ifndef SYNTHESIS
    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rvalid_i |-> (out_cnt_reg != 2'd0));
    a_fifo_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) fifo_push |-> (!fifo_full || fifo_pop));
`endif

endmodule
